// File: rtl/gg_nal_writer.sv
`timescale 1ns/1ps
// gg_nal_writer
//   Converts a stream of RBSP bytes (one NAL unit at a time) into an Annex-B
//   byte stream. It prepends a 3- or 4-byte start code and inserts emulation
//   prevention bytes (0x03) after two zeros when the next byte is 0x00..0x03.
//   It also appends a trailing 0x03 when the NAL ends in 0x00.
//
//   Optional feature macro: GG_NAL_EPB_COUNT_EN
//     defined   -> epb_count counts every emitted 0x03 that comes from
//                  emulation prevention or from the tail, wrapping.
//     undefined -> epb_count is tied to zero.
//
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. A valid side holds its data stable until that edge.
//
//   Ports
//     clk, reset     single clock, synchronous active-high reset
//     in_valid/in_ready/in_byte/in_first/in_last   RBSP byte input
//     long_sc        start-code length, sampled with the header byte
//     out_valid/out_ready/out_byte                 Annex-B byte output
//     out_nal_start  marks the first start-code byte of a NAL
//     out_nal_end    marks the last emitted byte of a NAL
//     epb_count      inserted-0x03 counter (CNT_WID bits)
module gg_nal_writer #(
  parameter int CNT_WID = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_byte,
  input  logic               in_first,
  input  logic               in_last,
  input  logic               long_sc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic               out_nal_start,
  output logic               out_nal_end,
  output logic [CNT_WID-1:0] epb_count
);

  typedef enum logic [2:0] {IDLE, SC, HDR, BODY, EPB, TAIL} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_out_valid, r_out_start, r_out_end;
  logic [7:0] r_out_byte;
  logic [7:0] r_hdr, r_pend;
  logic       r_hdr_last, r_pend_last;
  logic [1:0] r_sc_left, r_zcnt;

  logic       w_adv;        // output register is empty or being drained
  logic       w_in_ready;
  logic       w_load;       // load a new byte into the output register
  logic [7:0] w_byte;
  logic       w_start, w_end;
  logic       w_hdr_cap;
  logic [1:0] w_sc_left_nxt, w_zcnt_nxt;
  logic [7:0] w_pend_nxt;
  logic       w_pend_last_nxt;

  // Zero-run tracking, saturating at two.
  function automatic logic [1:0] zcnt_upd(input logic [1:0] z, input logic [7:0] b);
    if (b != 8'h00)   return 2'd0;
    else if (z == 2'd2) return 2'd2;
    else              return 2'(z + 2'd1);
  endfunction

  assign w_adv = !r_out_valid || out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready      = 1'b0;
    w_load          = 1'b0;
    w_byte          = 8'h00;
    w_start         = 1'b0;
    w_end           = 1'b0;
    w_hdr_cap       = 1'b0;
    w_sc_left_nxt   = r_sc_left;
    w_zcnt_nxt      = r_zcnt;
    w_pend_nxt      = r_pend;
    w_pend_last_nxt = r_pend_last;
    case (r_state)
      IDLE: begin
        // The header's first start-code byte is loaded in the same edge it is
        // accepted, so input is only taken once the previous NAL's last byte
        // has left the output register.
        w_in_ready = w_adv;
        if (in_valid && w_adv && in_first) begin
          w_hdr_cap     = 1'b1;
          w_load        = 1'b1;
          w_start       = 1'b1;
          w_sc_left_nxt = long_sc ? 2'd3 : 2'd2;
          w_state_nxt   = SC;
        end
      end
      SC: begin
        if (w_adv) begin
          w_load        = 1'b1;
          w_byte        = (r_sc_left == 2'd1) ? 8'h01 : 8'h00;
          w_sc_left_nxt = 2'(r_sc_left - 2'd1);
          if (r_sc_left == 2'd1) w_state_nxt = HDR;
        end
      end
      HDR: begin
        if (w_adv) begin
          w_load      = 1'b1;
          w_byte      = r_hdr;
          w_end       = r_hdr_last;
          w_zcnt_nxt  = 2'd0;
          w_state_nxt = r_hdr_last ? IDLE : BODY;
        end
      end
      BODY: begin
        w_in_ready = w_adv;
        if (in_valid && w_adv) begin
          w_load = 1'b1;
          if (r_zcnt == 2'd2 && in_byte <= 8'h03) begin
            // Emit the prevention byte now; the payload byte waits in r_pend.
            w_byte          = 8'h03;
            w_pend_nxt      = in_byte;
            w_pend_last_nxt = in_last;
            w_zcnt_nxt      = 2'd0;
            w_state_nxt     = EPB;
          end else begin
            w_byte     = in_byte;
            w_zcnt_nxt = zcnt_upd(r_zcnt, in_byte);
            if (in_last) begin
              if (in_byte == 8'h00) w_state_nxt = TAIL;
              else begin
                w_end       = 1'b1;
                w_state_nxt = IDLE;
              end
            end
          end
        end
      end
      EPB: begin
        if (w_adv) begin
          w_load     = 1'b1;
          w_byte     = r_pend;
          w_zcnt_nxt = zcnt_upd(r_zcnt, r_pend);
          if (r_pend_last) begin
            if (r_pend == 8'h00) w_state_nxt = TAIL;
            else begin
              w_end       = 1'b1;
              w_state_nxt = IDLE;
            end
          end else begin
            w_state_nxt = BODY;
          end
        end
      end
      TAIL: begin
        if (w_adv) begin
          w_load      = 1'b1;
          w_byte      = 8'h03;
          w_end       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_out_start <= 1'b0;
      r_out_end   <= 1'b0;
      r_hdr       <= 8'h00;
      r_hdr_last  <= 1'b0;
      r_sc_left   <= 2'd0;
      r_zcnt      <= 2'd0;
      r_pend      <= 8'h00;
      r_pend_last <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sc_left   <= w_sc_left_nxt;
      r_zcnt      <= w_zcnt_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_last <= w_pend_last_nxt;
      if (w_hdr_cap) begin
        r_hdr      <= in_byte;
        r_hdr_last <= in_last;
      end
      if (w_adv) begin
        r_out_valid <= w_load;
        if (w_load) begin
          r_out_byte  <= w_byte;
          r_out_start <= w_start;
          r_out_end   <= w_end;
        end
      end
    end
  end

  assign in_ready      = w_in_ready && !reset;
  assign out_valid     = r_out_valid;
  assign out_byte      = r_out_byte;
  assign out_nal_start = r_out_start;
  assign out_nal_end   = r_out_end;

`ifdef GG_NAL_EPB_COUNT_EN
  logic [CNT_WID-1:0] r_epb_count;
  logic               w_epb_inc;

  // Only prevention bytes and the tail 0x03 count; start-code 0x01 never does.
  assign w_epb_inc = w_load && ((r_state == TAIL) ||
                                (r_state == BODY && w_state_nxt == EPB));

  always_ff @(posedge clk) begin
    if (reset)          r_epb_count <= '0;
    else if (w_epb_inc) r_epb_count <= r_epb_count + CNT_WID'(1);
  end

  assign epb_count = r_epb_count;
`else
  assign epb_count = '0;
`endif

endmodule

// File: doc/gg_nal_writer.md
GG_NAL_WRITER -- requirements
Module: gg_nal_writer

Interface
REQ-001 SHALL have parameter CNT_WID, default 16, width of epb_count.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  RBSP byte offered.
REQ-005 SHALL have port in_ready  output  1  byte accepted when in_valid&&in_ready.
REQ-006 SHALL have port in_byte  input  8  RBSP byte; first byte of a NAL is the NAL header.
REQ-007 SHALL have port in_first  input  1  marks NAL header byte.
REQ-008 SHALL have port in_last  input  1  marks final RBSP byte of NAL (may coincide with in_first).
REQ-009 SHALL have port long_sc  input  1  sampled with header: 1 = 4-byte start code, 0 = 3-byte.
REQ-010 SHALL have port out_valid  output  1  out_byte valid.
REQ-011 SHALL have port out_ready  input  1  sink accepts when out_valid&&out_ready.
REQ-012 SHALL have port out_byte  output  8  Annex-B byte stream.
REQ-013 SHALL have port out_nal_start  output  1  flags first start-code byte.
REQ-014 SHALL have port out_nal_end  output  1  flags last emitted byte of NAL.
REQ-015 SHALL have port epb_count  output  CNT_WID  inserted 0x03 count (macro-gated, see Configuration).

Function
REQ-016 SHALL implement states IDLE, SC, HDR, BODY, EPB, TAIL.
REQ-017 IDLE: in_ready=1; byte with in_first latched as header with long_sc -> SC; byte without in_first accepted and dropped.
REQ-018 SC: emit 00 00 00 01 (long_sc=1) or 00 00 01 (long_sc=0), one byte per output handshake, out_nal_start on first -> HDR.
REQ-019 HDR: emit header byte; zero-run counter zcnt cleared; if header had in_last, out_nal_end on it -> IDLE, else -> BODY.
REQ-020 BODY: in_ready=!out_valid||out_ready; accepted byte b emitted directly, zcnt = (b==0) ? min(zcnt+1,2) : 0.
REQ-021 BODY: if zcnt==2 and b<=0x03, 0x03 emitted first, b held in pend register, state EPB, in_ready=0; zcnt=0 after 0x03.
REQ-022 EPB: emit pend byte, update zcnt per REQ-020, return BODY (or TAIL/IDLE per REQ-023).
REQ-023 Final byte (in_last) equal 0x00: after emitting it, state TAIL emits 0x03 with out_nal_end, -> IDLE; otherwise out_nal_end on final byte, -> IDLE.
REQ-024 in_first received outside IDLE SHALL be ignored (byte treated as payload).
REQ-025 Header accepted in cycle N: first start-code byte out_valid in cycle N+1; one byte per cycle thereafter when out_ready=1.
REQ-026 out_valid&&!out_ready: out_byte, out_nal_start, out_nal_end SHALL hold stable; no byte lost or duplicated.
REQ-027 Output SHALL be a registered stage; no combinational path in_valid->out_valid.

Reset
REQ-028 reset SHALL force state IDLE, out_valid=0, out_byte=0, out_nal_start=0, out_nal_end=0, zcnt=0, pend=0, epb_count=0 on next edge.
REQ-029 reset mid-NAL SHALL discard partial NAL; no trailing bytes emitted after reset deasserts.
REQ-030 in_ready SHALL be 0 while reset is asserted.

Configuration
REQ-031 With GG_NAL_EPB_COUNT_EN defined, epb_count SHALL increment (wrapping at 2^CNT_WID) for every emitted 0x03 from EPB insertion or TAIL, never for start-code bytes.
REQ-032 Without GG_NAL_EPB_COUNT_EN, epb_count SHALL be tied to 0 and counter logic omitted.

Verification
REQ-033 long_sc=1, bytes 27 42 e0 2a(last), out_ready=1 -> 00 00 00 01 27 42 e0 2a, start on first 00, end on 2a, first out one cycle after header.
REQ-034 long_sc=0, header 0a with in_first+in_last -> 00 00 01 0a, end on 0a.
REQ-035 header 21, payload 00 00 01 e4(last) -> 00 00 01 21 00 00 03 01 e4; payload 00 00 04 -> no insertion.
REQ-036 header 21, payload 00 00 00 00(last) -> ...21 00 00 03 00 00 03, end on final 03, epb_count=2 with macro, 0 without.
REQ-037 out_ready held low 5 cycles mid-payload -> out_byte stable, in_ready=0, full sequence intact afterwards.
REQ-038 reset pulsed after 2 payload bytes -> out_valid=0 next cycle, next NAL starts cleanly with start code.
